// File: rtl/argon_pkg.sv
// Argon core shared definitions: memory read masks,
// fetch FSM states and instruction width.
package argon_pkg;

  localparam int INSN_WIDTH = 32;

  localparam logic [2:0] RDMASK_XX = 3'b000;
  localparam logic [2:0] RDMASK_W  = 3'b010;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_FAULT
  } fetch_state_t;

endpackage

// File: rtl/argon_sync_fifo.sv
// Show-ahead synchronous FIFO with flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module argon_sync_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/argon_fetch_unit.sv
// Decoupled instruction fetch: own PC, credit-based memory
// requests, prefetch FIFO toward decode, redirect and flush.
module argon_fetch_unit
  import argon_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_redirect_valid,
  input  logic [XLEN-1:0]       i_redirect_pc,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [XLEN-1:0]       o_mem_addr,
  output logic [2:0]            o_mem_rd_mask,
  input  logic                  i_mem_rsp_valid,
  input  logic [INSN_WIDTH-1:0] i_mem_rsp_data,
  output logic                  o_inst_valid,
  input  logic                  i_inst_ready,
  output logic [INSN_WIDTH-1:0] o_inst,
  output logic [XLEN-1:0]       o_inst_pc,
  output logic                  o_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = INSN_WIDTH + XLEN;

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            req_q;
  logic            fault;

  logic [CW-1:0]   count;
  logic [CW-1:0]   count_n;
  logic [EW-1:0]   head;
  logic            empty;
  logic            accept;
  logic            push;
  logic            pop;
  logic            pending;
  logic            busy;
  logic            room_n;
  logic            misalign;

  assign accept   = req_q && i_mem_req_ready;
  assign pending  = (state == S_WAIT) || (state == S_DRAIN);
  assign push     = i_mem_rsp_valid && (state == S_WAIT)
                    && !i_redirect_valid;
  assign pop      = o_inst_valid && i_inst_ready
                    && !i_redirect_valid;
  assign count_n  = count + CW'(push) - CW'(pop);
  assign room_n   = count_n < CW'(FIFO_DEPTH);
  assign misalign = i_redirect_pc[1:0] != 2'b00;
  // a request stays in flight past this edge: must drain it
  assign busy     = accept || (pending && !i_mem_rsp_valid);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      req_q  <= 1'b0;
      fault  <= 1'b0;
    end else if (i_redirect_valid) begin
      pc    <= i_redirect_pc;
      fault <= misalign;
      req_q <= !busy && !misalign;
      if (busy)          state <= S_DRAIN;
      else if (misalign) state <= S_FAULT;
      else               state <= S_REQ;
    end else begin
      unique case (state)
        S_REQ: begin
          if (accept) begin
            pc     <= pc + XLEN'(4);
            req_pc <= pc;
            state  <= S_WAIT;
            req_q  <= 1'b0;
          end else begin
            req_q <= room_n;
          end
        end
        S_WAIT: begin
          if (i_mem_rsp_valid) begin
            state <= S_REQ;
            req_q <= room_n;
          end
        end
        S_DRAIN: begin
          if (i_mem_rsp_valid) begin
            state <= fault ? S_FAULT : S_REQ;
            req_q <= !fault && room_n;
          end
        end
        S_FAULT: req_q <= 1'b0;
      endcase
    end
  end

  argon_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push    (push),
    .pop     (pop),
    .flush   (i_redirect_valid),
    .wdata   ({i_mem_rsp_data, req_pc}),
    .rdata   (head),
    .count   (count),
    .empty   (empty)
  );

  assign o_mem_req_valid     = req_q;
  assign o_mem_addr          = pc;
  assign o_mem_rd_mask       = req_q ? RDMASK_W : RDMASK_XX;
  assign o_inst_valid        = !empty;
  assign {o_inst, o_inst_pc} = head;
  assign o_fault             = fault;

endmodule

// File: tb/tb_argon_fetch_unit.sv
// Scoreboard bench for argon_fetch_unit: memory model,
// expected instruction stream queue and decoupled monitor.
module tb_argon_fetch_unit;
  import argon_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        req_v;
  logic        req_rdy = 1'b0;
  logic [31:0] addr;
  logic [2:0]  mask;
  logic        rsp_v = 1'b0;
  logic [31:0] rsp_d = '0;
  logic        iv;
  logic        irdy = 1'b0;
  logic [31:0] ins;
  logic [31:0] ipc;
  logic        flt;

  always #5 clk = ~clk;

  argon_fetch_unit #(
    .XLEN       (32),
    .FIFO_DEPTH (4),
    .RESET_PC   (32'h0)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_redirect_valid (redir),
    .i_redirect_pc    (redir_pc),
    .o_mem_req_valid  (req_v),
    .i_mem_req_ready  (req_rdy),
    .o_mem_addr       (addr),
    .o_mem_rd_mask    (mask),
    .i_mem_rsp_valid  (rsp_v),
    .i_mem_rsp_data   (rsp_d),
    .o_inst_valid     (iv),
    .i_inst_ready     (irdy),
    .o_inst           (ins),
    .o_inst_pc        (ipc),
    .o_fault          (flt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  int          ready_mode = 0;
  int          dly_min = 1;
  int          dly_max = 1;
  bit          irdy_rand = 0;
  bit          irdy_fix = 1;
  bit          spur = 0;
  bit          mem_out = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_a = '0;
  bit          acc_now = 0;
  int          acc_cnt = 0;
  logic [31:0] acc_addr = '0;
  exp_t        exp_q[$];
  logic [31:0] gen_pc = '0;
  bit          gen_on = 1;
  bit          fault_model = 0;
  bit          pend_rst = 1;
  bit          pend_redir = 0;
  bit          pend_mis = 0;
  int          pop_cnt = 0;

  task automatic step(input bit rd, input logic [31:0] tgt,
                      input bit rs);
    exp_t e;
    @(posedge clk);
    #1;
    if (pend_rst) fault_model = 1'b0;
    else if (pend_redir) fault_model = pend_mis;
    rsp_v = 1'b0;
    rsp_d = $urandom;
    if (rs) begin
      mem_out = 1'b0;
    end else if (mem_out) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rsp_v = 1'b1;
        rsp_d = memf(mem_a);
        mem_out = 1'b0;
      end
    end else if (spur && $urandom_range(0, 7) == 0) begin
      rsp_v = 1'b1;
    end
    if (ready_mode == 0) req_rdy = 1'b1;
    else if (ready_mode == 1) req_rdy = ($urandom_range(0, 3) != 0);
    else req_rdy = 1'b0;
    irdy = irdy_rand ? ($urandom_range(0, 2) != 0) : irdy_fix;
    rst = rs;
    redir = rd;
    redir_pc = tgt;
    acc_now = req_v && req_rdy && !rs;
    if (acc_now) begin
      mem_out = 1'b1;
      mem_a = addr;
      mem_cnt = int'($urandom_range(dly_max, dly_min));
      acc_cnt++;
      acc_addr = addr;
    end
    pend_rst = rs;
    pend_redir = rd;
    pend_mis = (tgt[1:0] != 2'b00);
    if (rs) begin
      exp_q.delete();
      gen_pc = 32'h0;
      gen_on = 1'b1;
    end else if (rd) begin
      exp_q.delete();
      gen_pc = tgt;
      gen_on = !pend_mis;
    end
    while (gen_on && exp_q.size() < 8) begin
      e.pc = gen_pc;
      e.ins = memf(gen_pc);
      exp_q.push_back(e);
      gen_pc += 32'd4;
    end
  endtask

  task automatic wait_acc(input string nm);
    int n = 0;
    do begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end while (!acc_now && n < 40);
    if (!acc_now) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for request", nm);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
  endtask

  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic        pred = 1'b0;
  logic        prst = 1'b1;
  logic [31:0] pa = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("rd_mask", 64'(mask), 64'(req_v ? RDMASK_W : RDMASK_XX));
      chk("fault", 64'(flt), 64'(fault_model));
      if (fault_model) chk("halted", 64'({req_v, iv}), 64'(0));
      if (pv && !pr && !pred && !prst)
        chk("req_hold", 64'({req_v, addr}), 64'({1'b1, pa}));
      if (iv && irdy && !redir) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_empty actual_pc=%0h required=none", ipc);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", 64'(ipc), 64'(e.pc));
          chk("inst", 64'(ins), 64'(e.ins));
        end
      end
    end
    pv = req_v;
    pr = req_rdy;
    pred = redir;
    prst = rst;
    pa = addr;
  end

  initial begin
    int a0;
    int p0;
    int n;
    int k;
    logic [31:0] t;

    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("rst_req", 64'(req_v), 64'(0));
    chk("rst_iv", 64'(iv), 64'(0));
    chk("rst_fault", 64'(flt), 64'(0));
    chk("rst_mask", 64'(mask), 64'(RDMASK_XX));

    wait_acc("first_req");
    chk("first_addr", 64'(acc_addr), 64'(32'h0));
    idle(10);
    p0 = pop_cnt;
    idle(40);
    chk("throughput", 64'(pop_cnt - p0), 64'(20));

    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    k = 0;
    do begin
      wait_acc("hold_pre");
      k++;
    end while (acc_addr != 32'h4 && k < 4);
    ready_mode = 2;
    n = 0;
    do begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end while (!req_v && n < 6);
    for (int i = 0; i < 3; i++) begin
      chk("hold_addr", 64'({req_v, addr}), 64'({1'b1, 32'h8}));
      if (i < 2) step(1'b0, 32'h0, 1'b0);
    end
    ready_mode = 0;
    step(1'b0, 32'h0, 1'b0);
    chk("hold_acc", 64'(acc_addr), 64'(32'h8));
    wait_acc("after_hold");
    chk("after_hold_addr", 64'(acc_addr), 64'(32'hC));

    irdy_fix = 1'b0;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    a0 = acc_cnt;
    idle(30);
    chk("credit_reqs", 64'(acc_cnt - a0), 64'(4));
    chk("credit_idle", 64'(req_v), 64'(0));
    chk("credit_full", 64'(iv), 64'(1));
    irdy_fix = 1'b1;
    wait_acc("resume");
    chk("resume_addr", 64'(acc_addr), 64'(32'h10));

    irdy_fix = 1'b0;
    idle(20);
    step(1'b1, 32'h40, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("lat_req", 64'({req_v, addr}), 64'({1'b1, 32'h40}));
    chk("lat_n1_iv", 64'(iv), 64'(0));
    step(1'b0, 32'h0, 1'b0);
    chk("lat_n2_iv", 64'(iv), 64'(0));
    step(1'b0, 32'h0, 1'b0);
    chk("lat_n3", 64'({iv, ipc}), 64'({1'b1, 32'h40}));
    irdy_fix = 1'b1;
    idle(10);

    dly_min = 4;
    dly_max = 4;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    k = 0;
    do begin
      wait_acc("drain_pre");
      k++;
    end while (acc_addr != 32'h8 && k < 6);
    chk("drain_acc", 64'(acc_addr), 64'(32'h8));
    step(1'b1, 32'h100, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("drain_flush", 64'(iv), 64'(0));
    p0 = pop_cnt;
    idle(30);
    chk("drain_progress", 64'(pop_cnt - p0 >= 3), 64'(1));

    dly_min = 1;
    dly_max = 1;
    step(1'b1, 32'h102, 1'b0);
    a0 = acc_cnt;
    step(1'b0, 32'h0, 1'b0);
    chk("mis_fault", 64'(flt), 64'(1));
    idle(8);
    chk("mis_noreq", 64'(acc_cnt - a0), 64'(0));
    step(1'b1, 32'h200, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("clr_fault", 64'(flt), 64'(0));
    chk("clr_req", 64'({req_v, addr}), 64'({1'b1, 32'h200}));
    idle(10);

    dly_min = 3;
    dly_max = 3;
    wait_acc("mis_wait_pre");
    step(1'b1, 32'h33, 1'b0);
    a0 = acc_cnt;
    idle(8);
    chk("mis_wait_fault", 64'(flt), 64'(1));
    chk("mis_wait_noreq", 64'(acc_cnt - a0), 64'(0));
    dly_min = 1;
    dly_max = 1;
    step(1'b1, 32'h400, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("mis_wait_resume", 64'({req_v, addr}),
        64'({1'b1, 32'h400}));
    idle(6);

    step(1'b1, 32'hFFFF_FFFC, 1'b0);
    p0 = pop_cnt;
    idle(16);
    chk("wrap_progress", 64'(pop_cnt - p0 >= 3), 64'(1));

    ready_mode = 1;
    dly_min = 1;
    dly_max = 3;
    irdy_rand = 1'b1;
    spur = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        step(1'b0, 32'h0, 1'b1);
      end else if ($urandom_range(0, 19) == 0) begin
        t = 32'($urandom_range(0, 1023)) << 2;
        if ($urandom_range(0, 7) == 0)
          t[1:0] = 2'($urandom_range(1, 3));
        step(1'b1, t, 1'b0);
      end else begin
        step(1'b0, 32'h0, 1'b0);
      end
    end
    step(1'b1, 32'h800, 1'b0);
    p0 = pop_cnt;
    idle(60);
    chk("rand_tail", 64'(pop_cnt - p0 >= 3), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/argon_fetch_unit.md
Name: argon_fetch_unit

Overview:
Parametrised instruction-fetch front end for the Argon core. It replaces the single-shot IF stage with a decoupled fetch engine that has its own PC, a memory request/response handshake that tolerates wait states, and a prefetch FIFO of depth FIFO_DEPTH toward decode. It supports PC redirect with flush for branches and jumps, and detects misaligned redirect targets.

Parameters:
XLEN, 32, address/PC width (≥16)
FIFO_DEPTH, 4, prefetch entries; power of two, ≥2
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned

Ports:
i_clk  in  1  core clock
i_reset  in  1  synchronous, active-high reset
i_redirect_valid  in  1  load new fetch PC and flush (branch/jump/jalr)
i_redirect_pc  in  XLEN  redirect target
o_mem_req_valid  out  1  fetch request valid
i_mem_req_ready  in  1  memory accepts request
o_mem_addr  out  XLEN  word address of request
o_mem_rd_mask  out  3  always RDMASK_W while o_mem_req_valid, else RDMASK_XX
i_mem_rsp_valid  in  1  read data valid
i_mem_rsp_data  in  32  instruction word
o_inst_valid  out  1  FIFO head valid
i_inst_ready  in  1  decode consumes head
o_inst  out  32  head instruction
o_inst_pc  out  XLEN  PC of head instruction
o_fault  out  1  sticky misaligned-redirect fault

Behaviour:
- Clock and reset: one clock i_clk; i_reset is synchronous and active-high.
- Reset values: o_mem_req_valid=0, o_inst_valid=0, o_fault=0, FIFO empty, fetch PC=RESET_PC, state=S_REQ. Reset mid-operation drops any outstanding request; FIFO contents are discarded.
- States:
  - S_REQ: assert o_mem_req_valid with o_mem_addr=PC when credit exists.
  - S_WAIT: one request outstanding; await response.
  - S_DRAIN: outstanding response must be discarded.
  - S_FAULT: fetching halted.
- Credit rule: issue only if fifo_count + outstanding < FIFO_DEPTH, so a response never finds the FIFO full. At most one request is outstanding.
- S_REQ transitions:
  - valid&&ready: PC <= PC+4 (mod 2^XLEN, wraps silently); go to S_WAIT.
  - Once asserted, o_mem_req_valid and o_mem_addr stay stable until accepted, except on redirect.
- S_WAIT transitions:
  - i_mem_rsp_valid: push {i_mem_rsp_data, request PC} into the FIFO; go to S_REQ.
  - The next request is asserted the following cycle, so peak throughput is 1 instruction per 2 cycles.
- Response contract: the memory returns at earliest one cycle after acceptance. rsp_valid in S_REQ or S_FAULT (nothing outstanding) is ignored.
- Decode side: o_inst_valid = FIFO not empty; show-ahead, so head data are valid combinationally from FIFO registers. Pop on o_inst_valid && i_inst_ready.
- Simultaneous push and pop: both occur; count is unchanged.
- Redirect (priority over every other event in its cycle):
  - FIFO flushed; any pop or push in that cycle is discarded.
  - PC <= i_redirect_pc.
  - o_mem_req_valid drops that cycle's following edge, and the new request appears at N+1.
  - State after redirect:
    - Redirect in S_WAIT without rsp_valid, or redirect coinciding with request acceptance: S_DRAIN.
    - Redirect in S_WAIT coinciding with rsp_valid: response dropped; S_REQ.
  - Repeated redirect in S_DRAIN: update PC, stay in S_DRAIN.
- S_DRAIN: on rsp_valid, discard the data; go to S_REQ with the current PC.
- Misaligned redirect (i_redirect_pc[1:0]!=0): flush as above; o_fault=1 and state S_FAULT (after draining if a request is outstanding); no requests issued.
- Clearing the fault: o_fault clears only on an aligned redirect or reset; that redirect resumes normal fetch.
- Latency: redirect at cycle N, zero-wait memory (ready=1, rsp at acceptance+1):
  - request at N+1
  - response at N+2
  - o_inst_valid at N+3 with o_inst_pc = target

Decomposition:
- argon_pkg: RDMASK_W/RDMASK_XX constants (shared with the core memory path), fetch_state_t enum {S_REQ,S_WAIT,S_DRAIN,S_FAULT}, INSN_WIDTH=32.
- Sub-module argon_sync_fifo:
  - Parameters: WIDTH, DEPTH.
  - Interface: push, pop, flush, count, show-ahead read.
  - Instantiated with WIDTH=32+XLEN.
- FSM and PC remain in argon_fetch_unit.

Test Plan:
- Reset, zero-wait memory, i_inst_ready=1 → requests at 0x0, 0x4, 0x8…; o_inst_pc matches; one instruction every 2 cycles; o_fault=0.
- i_inst_ready=0, FIFO_DEPTH=4 → exactly 4 requests issued, then o_mem_req_valid stays 0; release ready → fetching resumes at 0x10 with no duplicates or gaps.
- i_mem_req_ready low 3 cycles → o_mem_addr held stable at 0x8 throughout; PC advances only on acceptance.
- Redirect to 0x100 while a response for 0x8 is outstanding (rsp 4 cycles later) → FIFO empty next cycle; 0x8 data never appear; first o_inst_pc=0x100.
- Redirect to 0x102 → o_fault=1, no requests issued; redirect to 0x200 → o_fault=0, fetch resumes at 0x200.
- PC near wrap: redirect to 0xFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000.
